// File: rtl/stream_tgen.sv
// Stream traffic generator/checker: drives a patterned write stream and checks a read stream.
// Optional LFSR pattern source is enabled with `define STREAM_TGEN_LFSR_EN.
module stream_tgen #(
  parameter int CONFIG_AWIDTH = 5,
  parameter int CONFIG_DWIDTH = 32,
  parameter int STREAM_WIDTH  = 32,
  parameter int CONFIG_BASE   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CONFIG_AWIDTH-1:0] cfg_addr,
  input  logic [CONFIG_DWIDTH-1:0] cfg_data,
  input  logic                     cfg_valid,
  output logic [STREAM_WIDTH-1:0]  gen_data,
  output logic                     gen_valid,
  input  logic                     gen_ready,
  input  logic [STREAM_WIDTH-1:0]  chk_data,
  input  logic                     chk_valid,
  output logic                     chk_ready,
  output logic                     gen_busy,
  output logic                     chk_busy,
  output logic                     chk_done,
  output logic [CONFIG_DWIDTH-1:0] chk_err_cnt,
  output logic [CONFIG_DWIDTH-1:0] chk_word_cnt,
  output logic [STREAM_WIDTH-1:0]  chk_first_err
);

  localparam logic [CONFIG_AWIDTH-1:0] A_GEN_LEN = CONFIG_AWIDTH'(CONFIG_BASE);
  localparam logic [CONFIG_AWIDTH-1:0] A_SEED    = CONFIG_AWIDTH'(CONFIG_BASE + 1);
  localparam logic [CONFIG_AWIDTH-1:0] A_CHK_LEN = CONFIG_AWIDTH'(CONFIG_BASE + 2);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t r_gen_state, w_gen_state_nxt;
  state_t r_chk_state, w_chk_state_nxt;

  logic [STREAM_WIDTH-1:0]  r_seed;
  logic [STREAM_WIDTH-1:0]  r_gen_pat;
  logic [CONFIG_DWIDTH-1:0] r_gen_len;
  logic [CONFIG_DWIDTH-1:0] r_gen_cnt;
  logic [STREAM_WIDTH-1:0]  r_chk_exp;
  logic [CONFIG_DWIDTH-1:0] r_chk_len;
  logic [CONFIG_DWIDTH-1:0] r_chk_err;
  logic [CONFIG_DWIDTH-1:0] r_chk_cnt;
  logic [STREAM_WIDTH-1:0]  r_chk_first;
  logic                     r_chk_done;

  logic w_gen_start, w_chk_start, w_gen_fire, w_chk_fire, w_gen_last, w_chk_last;
  logic w_len_nz;

`ifdef STREAM_TGEN_LFSR_EN
  localparam logic [CONFIG_AWIDTH-1:0] A_MODE = CONFIG_AWIDTH'(CONFIG_BASE + 3);
  logic r_mode, r_gen_mode, r_chk_mode;

  // Galois LFSR x^32+x^22+x^2+x+1 over the low 32 bits of the pattern.
  function automatic logic [STREAM_WIDTH-1:0] f_advance(input logic [STREAM_WIDTH-1:0] cur,
                                                        input logic lfsr);
    logic [31:0] l;
    l = 32'(cur);
    if (lfsr) return STREAM_WIDTH'((l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0));
    return cur + STREAM_WIDTH'(1);
  endfunction

  function automatic logic [STREAM_WIDTH-1:0] f_seed(input logic [STREAM_WIDTH-1:0] seed,
                                                     input logic lfsr);
    if (lfsr && seed == '0) return STREAM_WIDTH'(1);
    return seed;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode     <= 1'b0;
      r_gen_mode <= 1'b0;
      r_chk_mode <= 1'b0;
    end else begin
      if (cfg_valid && cfg_addr == A_MODE) r_mode <= cfg_data[0];
      if (w_gen_start) r_gen_mode <= r_mode;
      if (w_chk_start) r_chk_mode <= r_mode;
    end
  end
`else
  function automatic logic [STREAM_WIDTH-1:0] f_advance(input logic [STREAM_WIDTH-1:0] cur);
    return cur + STREAM_WIDTH'(1);
  endfunction
`endif

  assign w_len_nz    = (cfg_data != '0);
  assign w_gen_start = cfg_valid && cfg_addr == A_GEN_LEN && w_len_nz && r_gen_state == S_IDLE;
  assign w_chk_start = cfg_valid && cfg_addr == A_CHK_LEN && w_len_nz && r_chk_state == S_IDLE;
  assign w_gen_fire  = (r_gen_state == S_RUN) && gen_ready;
  assign w_chk_fire  = (r_chk_state == S_RUN) && chk_valid;
  assign w_gen_last  = w_gen_fire && (r_gen_cnt == r_gen_len - CONFIG_DWIDTH'(1));
  assign w_chk_last  = w_chk_fire && (r_chk_cnt == r_chk_len - CONFIG_DWIDTH'(1));

  always_comb begin
    w_gen_state_nxt = r_gen_state;
    w_chk_state_nxt = r_chk_state;
    case (r_gen_state)
      S_IDLE:  if (w_gen_start) w_gen_state_nxt = S_RUN;
      S_RUN:   if (w_gen_last)  w_gen_state_nxt = S_IDLE;
      default: w_gen_state_nxt = S_IDLE;
    endcase
    case (r_chk_state)
      S_IDLE:  if (w_chk_start) w_chk_state_nxt = S_RUN;
      S_RUN:   if (w_chk_last)  w_chk_state_nxt = S_IDLE;
      default: w_chk_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gen_state <= S_IDLE;
      r_chk_state <= S_IDLE;
      r_seed      <= '0;
      r_gen_pat   <= '0;
      r_gen_len   <= '0;
      r_gen_cnt   <= '0;
      r_chk_exp   <= '0;
      r_chk_len   <= '0;
      r_chk_err   <= '0;
      r_chk_cnt   <= '0;
      r_chk_first <= '0;
      r_chk_done  <= 1'b0;
    end else begin
      r_gen_state <= w_gen_state_nxt;
      r_chk_state <= w_chk_state_nxt;
      if (cfg_valid && cfg_addr == A_SEED) r_seed <= cfg_data[STREAM_WIDTH-1:0];

      // The seed is sampled at run start, so later SEED writes only affect the next run.
      if (w_gen_start) begin
        r_gen_len <= cfg_data;
        r_gen_cnt <= '0;
`ifdef STREAM_TGEN_LFSR_EN
        r_gen_pat <= f_seed(r_seed, r_mode);
`else
        r_gen_pat <= r_seed;
`endif
      end else if (w_gen_fire) begin
        r_gen_cnt <= r_gen_cnt + CONFIG_DWIDTH'(1);
`ifdef STREAM_TGEN_LFSR_EN
        r_gen_pat <= f_advance(r_gen_pat, r_gen_mode);
`else
        r_gen_pat <= f_advance(r_gen_pat);
`endif
      end

      if (w_chk_start) begin
        r_chk_len   <= cfg_data;
        r_chk_cnt   <= '0;
        r_chk_err   <= '0;
        r_chk_first <= '0;
        r_chk_done  <= 1'b0;
`ifdef STREAM_TGEN_LFSR_EN
        r_chk_exp   <= f_seed(r_seed, r_mode);
`else
        r_chk_exp   <= r_seed;
`endif
      end else if (w_chk_fire) begin
        r_chk_cnt <= r_chk_cnt + CONFIG_DWIDTH'(1);
`ifdef STREAM_TGEN_LFSR_EN
        r_chk_exp <= f_advance(r_chk_exp, r_chk_mode);
`else
        r_chk_exp <= f_advance(r_chk_exp);
`endif
        if (chk_data != r_chk_exp) begin
          if (r_chk_err == '0) r_chk_first <= chk_data;
          if (r_chk_err != '1) r_chk_err <= r_chk_err + CONFIG_DWIDTH'(1);
        end
        if (w_chk_last) r_chk_done <= 1'b1;
      end
    end
  end

  assign gen_data      = r_gen_pat;
  assign gen_valid     = (r_gen_state == S_RUN);
  assign gen_busy      = (r_gen_state == S_RUN);
  assign chk_ready     = (r_chk_state == S_RUN);
  assign chk_busy      = (r_chk_state == S_RUN);
  assign chk_done      = r_chk_done;
  assign chk_err_cnt   = r_chk_err;
  assign chk_word_cnt  = r_chk_cnt;
  assign chk_first_err = r_chk_first;

endmodule

// File: doc/stream_tgen.md
# stream_tgen

Configurable stream traffic generator and checker for the AXI streaming engine's system-side ports. The generator drives the engine's write stream (toward DDR); the checker consumes its read stream (from DDR) and compares each word against the same regenerated pattern. Both are programmed through the shared config write bus (addr/data/valid). Status is exported for the top-level config read mux.

## Interface
- CONFIG_AWIDTH, 5: config address width.
- CONFIG_DWIDTH, 32: config data width.
- STREAM_WIDTH, 32: stream data width; must be ≤ CONFIG_DWIDTH.
- CONFIG_BASE, 8: register block base address; occupies CONFIG_BASE+0..+3.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_addr  in  CONFIG_AWIDTH  config write address.
- cfg_data  in  CONFIG_DWIDTH  config write data.
- cfg_valid  in  1  config write strobe, single cycle.
- gen_data  out  STREAM_WIDTH  generated word to engine write port.
- gen_valid  out  1  generated word valid.
- gen_ready  in  1  engine write port ready.
- chk_data  in  STREAM_WIDTH  word from engine read port.
- chk_valid  in  1  read word valid.
- chk_ready  out  1  checker accepts word.
- gen_busy  out  1  generator running.
- chk_busy  out  1  checker running.
- chk_done  out  1  sticky; checker completed a run.
- chk_err_cnt  out  CONFIG_DWIDTH  mismatch count, saturating.
- chk_word_cnt  out  CONFIG_DWIDTH  words accepted in current/last run.
- chk_first_err  out  STREAM_WIDTH  received value of first mismatching word.

## Operation
- Registers (written when cfg_valid and cfg_addr matches):
  - +0 GEN_LEN: writing L≠0 in IDLE starts the generator for L words. L=0, or a write while running, is ignored.
  - +1 SEED: start value for both pattern sources, latched at each run start.
  - +2 CHK_LEN: writing L≠0 in IDLE starts the checker for L words. It clears chk_done, chk_err_cnt, chk_word_cnt and chk_first_err. L=0, or a write while running, is ignored.
  - +3 MODE: bit0 selects the pattern; see Configuration.
- Pattern advance: counter mode computes next = cur+1 modulo 2^STREAM_WIDTH, with wrap from all-ones to 0.
- Generator FSM:
  - IDLE→RUN on a valid GEN_LEN write.
  - In RUN, gen_valid=1 and gen_data=current pattern. On gen_valid&gen_ready, the pattern advances and the count increments.
  - RUN→IDLE on the handshake of word L. gen_valid deasserts the following cycle.
  - gen_data stays stable while gen_valid&~gen_ready.
- Checker FSM:
  - IDLE→RUN on a valid CHK_LEN write. chk_ready=1 only in RUN.
  - On each chk_valid&chk_ready, compare chk_data with the expected pattern. On mismatch, increment chk_err_cnt, saturating at all-ones; the first mismatch captures chk_first_err.
  - The expected pattern advances on every accepted word.
  - RUN→IDLE on word L, setting chk_done.
- Generator and checker run independently. A SEED or MODE write while running does not affect the current run.
- Reset values: gen_valid=0, chk_ready=0, gen_busy=0, chk_busy=0, chk_done=0, all counters 0, gen_data=0, chk_first_err=0, MODE=0, SEED=0, both FSMs IDLE.
- Reset mid-run aborts both runs immediately. No partial state survives.

## Timing
- Config write at cycle N → gen_valid/gen_busy (or chk_ready/chk_busy) high at N+1.
- Throughput is one word per cycle when the partner holds ready/valid high.
- All outputs are registered.
- chk_err_cnt and chk_word_cnt update the cycle after the accepting handshake.
- chk_done rises the cycle after the last accepted word.
- A GEN_LEN write coincident with the final handshake is ignored, because the FSM is still in RUN.

## Configuration
- STREAM_TGEN_LFSR_EN defined:
  - MODE bit0=1 selects a Galois LFSR, x^32+x^22+x^2+x+1, mask 0x80200003, applied on the low 32 bits.
  - With bit0=1, a seed of 0 is replaced by 1 at run start.
  - MODE bit0=0 selects counter mode.
- Undefined: MODE writes are ignored and only counter mode exists. No LFSR logic is synthesised.

## Test plan
- SEED=5, GEN_LEN=4, gen_ready=1 → gen_data 5,6,7,8 on four consecutive cycles, then gen_valid=0 and gen_busy=0.
- gen_ready toggling 1,0,0,1,1 with GEN_LEN=3, SEED=0 → gen_data holds while stalled; accepted words are 0,1,2.
- SEED=0xFFFFFFFE, CHK_LEN=3, feed 0xFFFFFFFE, 0xFFFFFFFF, 0 → chk_err_cnt=0, chk_word_cnt=3, chk_done=1.
- CHK_LEN=4, SEED=10, feed 10, 99, 12, 77 → chk_err_cnt=2, chk_first_err=99.
- Loop gen→chk with LFSR mode (macro defined), SEED=0, both LEN=16 → first word 1, chk_err_cnt=0. Mid-run rst_n low → all outputs return to reset values the next cycle.
- GEN_LEN=0 write and a GEN_LEN write while busy → no change to gen_busy or the word count.
